// File: rtl/gci_std_display_mem_arbiter.sv
// Display memory arbiter: shares one memory request port between the
// scan-out read path and the command write path. Grants alternate in
// bounded bursts. An urgent read preempts a write burst, and reads in
// flight are capped. Requests pass through one registered output stage.
module gci_std_display_mem_arbiter #(
  parameter int P_MEM_ADDR_N     = 23,
  parameter int P_BURST          = 8,
  parameter int P_RD_OUTSTANDING = 4
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  // read requester
  input  logic                    iRD_VALID,
  output logic                    oRD_BUSY,
  input  logic [P_MEM_ADDR_N-1:0] iRD_ADDR,
  input  logic                    iRD_URGENT,
  output logic                    oRD_DATA_VALID,
  output logic [31:0]             oRD_DATA,
  // write requester
  input  logic                    iWR_VALID,
  output logic                    oWR_BUSY,
  input  logic [P_MEM_ADDR_N-1:0] iWR_ADDR,
  input  logic [23:0]             iWR_DATA,
  // memory port
  output logic                    oMEM_VALID,
  input  logic                    iMEM_BUSY,
  output logic                    oMEM_RW,
  output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
  output logic [31:0]             oMEM_DATA,
  input  logic                    iMEM_RD_VALID,
  input  logic [31:0]             iMEM_RD_DATA
);

  localparam int              BURST_W   = $clog2(P_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(P_BURST);
  localparam logic [3:0]      RD_MAX    = 4'(P_RD_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
  typedef enum logic       {GRANT_RD, GRANT_WR} grant_t;

  state_t                  state_q, state_d;
  grant_t                  last_q, last_d;
  logic [BURST_W-1:0]      burst_q, burst_d, burst_next;
  logic [3:0]              outst_q, outst_d;

  logic                    mem_valid_q, mem_rw_q;
  logic [P_MEM_ADDR_N-1:0] mem_addr_q;
  logic [31:0]             mem_data_q;
  logic                    rd_data_valid_q;
  logic [31:0]             rd_data_q;

  logic stage_free, rd_room, rd_busy, wr_busy, rd_acc, wr_acc, rd_ret, rd_req;

  // Handshake: the output stage can take a new request when it is empty or draining.
  always_comb begin
    stage_free = !mem_valid_q || !iMEM_BUSY;
    rd_room    = outst_q < RD_MAX;
    rd_busy    = !(state_q == S_RD && stage_free && rd_room);
    wr_busy    = !(state_q == S_WR && stage_free);
    rd_acc     = iRD_VALID && !rd_busy;
    wr_acc     = iWR_VALID && !wr_busy;
    // A return with nothing outstanding is stale (e.g. issued before reset).
    rd_ret     = iMEM_RD_VALID && (outst_q != 4'd0);
    rd_req     = iRD_VALID && rd_room;
    outst_d    = outst_q + 4'(rd_acc) - 4'(rd_ret);
    // Saturate so an urgent read burst running past the limit cannot wrap.
    burst_next = ((rd_acc || wr_acc) && burst_q != BURST_MAX) ? burst_q + 1'b1 : burst_q;
  end

  // Grant FSM: next state, last-grant and burst counter.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_next;
    unique case (state_q)
      S_IDLE: begin
        burst_d = '0;
        if (rd_req && (iRD_URGENT || !iWR_VALID || last_q == GRANT_WR)) begin
          state_d = S_RD;
          last_d  = GRANT_RD;
        end else if (iWR_VALID) begin
          state_d = S_WR;
          last_d  = GRANT_WR;
        end
      end
      S_RD: begin
        if (!iRD_VALID || outst_d == RD_MAX ||
            (burst_next == BURST_MAX && !(iRD_URGENT && !iWR_VALID)))
          state_d = S_IDLE;
      end
      S_WR: begin
        if (!iWR_VALID || burst_next == BURST_MAX || (iRD_URGENT && iRD_VALID))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!inRESET) begin
      state_q <= S_IDLE;
      last_q  <= GRANT_WR;
      burst_q <= '0;
      outst_q <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      outst_q <= outst_d;
    end
  end

  // Output request stage: load on accept, hold while memory stalls, else drain.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= 32'd0;
    end else if (rd_acc) begin
      mem_valid_q <= 1'b1;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= iRD_ADDR;
      mem_data_q  <= 32'd0;
    end else if (wr_acc) begin
      mem_valid_q <= 1'b1;
      mem_rw_q    <= 1'b1;
      mem_addr_q  <= iWR_ADDR;
      mem_data_q  <= {8'h00, iWR_DATA};
    end else if (!iMEM_BUSY) begin
      mem_valid_q <= 1'b0;
    end
  end

  // Read data return: one register stage, no backpressure.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rd_data_valid_q <= 1'b0;
      rd_data_q       <= 32'd0;
    end else begin
      rd_data_valid_q <= iMEM_RD_VALID;
      rd_data_q       <= iMEM_RD_DATA;
    end
  end

  assign oRD_BUSY       = rd_busy;
  assign oWR_BUSY       = wr_busy;
  assign oMEM_VALID     = mem_valid_q;
  assign oMEM_RW        = mem_rw_q;
  assign oMEM_ADDR      = mem_addr_q;
  assign oMEM_DATA      = mem_data_q;
  assign oRD_DATA_VALID = rd_data_valid_q;
  assign oRD_DATA       = rd_data_q;

endmodule

// File: doc/gci_std_display_mem_arbiter.md
Name: gci_std_display_mem_arbiter

Overview:
- Shares the single display-memory request port between two requesters.
- Read requester: scan-out/refresh path, issues pixel fetches and receives returned data.
- Write requester: command path output (bitmap/character/sequencer writes).
- Burst-limited alternating arbitration, urgent-read preemption, outstanding-read limit, one-entry registered request stage toward memory.

Parameters:
P_MEM_ADDR_N, 23, memory word address width
P_BURST, 8, max transfers accepted per grant before re-arbitration (>=1)
P_RD_OUTSTANDING, 4, max reads issued without returned data (>=1, <=15)

Ports:
iCLOCK  in  1  clock
inRESET  in  1  async reset, active low
iRD_VALID  in  1  read request valid
oRD_BUSY  out  1  read request not accepted this cycle
iRD_ADDR  in  P_MEM_ADDR_N  read address
iRD_URGENT  in  1  scan-out FIFO below threshold; read gets priority
oRD_DATA_VALID  out  1  returned read data valid
oRD_DATA  out  32  returned read data
iWR_VALID  in  1  write request valid
oWR_BUSY  out  1  write request not accepted this cycle
iWR_ADDR  in  P_MEM_ADDR_N  write address
iWR_DATA  in  24  write pixel data (RGB)
oMEM_VALID  out  1  memory request valid
iMEM_BUSY  in  1  memory stalls request
oMEM_RW  out  1  1 = write, 0 = read
oMEM_ADDR  out  P_MEM_ADDR_N  memory address
oMEM_DATA  out  32  write data, {8'h00, pixel}
iMEM_RD_VALID  in  1  memory read data return
iMEM_RD_DATA  in  32  memory read data

Behaviour:
- Reset (async, inRESET low):
  - State S_IDLE; burst counter 0; outstanding counter 0; last-grant = WR.
  - oMEM_VALID/oMEM_RW = 0; oMEM_ADDR/oMEM_DATA = 0.
  - oRD_DATA_VALID = 0, oRD_DATA = 0.
  - oRD_BUSY = oWR_BUSY = 1.
- Transfer rule: a transfer occurs on a requester when VALID && !BUSY at a clock edge.
- Output stage: stage_free = !oMEM_VALID || !iMEM_BUSY.
  - Accepted request loads the output register next cycle (latency 1).
  - Otherwise oMEM_VALID clears when !iMEM_BUSY.
  - Register holds stable while iMEM_BUSY.
- oRD_BUSY = !(state==S_RD && stage_free && outstanding<P_RD_OUTSTANDING).
- oWR_BUSY = !(state==S_WR && stage_free). Both BUSY in S_IDLE.
- States:
  - S_IDLE, grant decision (1 cycle, no accept). rd_req = iRD_VALID && outstanding<P_RD_OUTSTANDING.
    - If rd_req && (iRD_URGENT || !iWR_VALID || last-grant==WR) -> S_RD, last-grant = RD.
    - Else if iWR_VALID -> S_WR, last-grant = WR.
    - Else stay. Burst counter cleared on leaving.
  - S_RD: counter increments per accepted read. Return to S_IDLE at the edge where any of these holds:
    - counter reaches P_BURST;
    - !iRD_VALID;
    - outstanding reaches P_RD_OUTSTANDING.
    - Exception: if iRD_URGENT && !iWR_VALID, the P_BURST limit is ignored.
  - S_WR: counter increments per accepted write. Return to S_IDLE when:
    - counter reaches P_BURST;
    - !iWR_VALID;
    - iRD_URGENT && iRD_VALID (preemption): the write accepted that cycle, if any, completes; no further write accepted.
- Outstanding counter (4 bit):
  - +1 on accepted read; -1 on iMEM_RD_VALID; both in the same cycle -> unchanged.
  - iMEM_RD_VALID at 0 is ignored (no underflow).
- Return path: oRD_DATA_VALID/oRD_DATA = iMEM_RD_VALID/iMEM_RD_DATA registered, 1 cycle. No backpressure.
- Ordering: requests leave in acceptance order; no reordering.
- Reset mid-operation: pending output request dropped, counters cleared; in-flight returns after reset are ignored by the counter.

Test Plan:
1. Reset with iRD_VALID=iWR_VALID=1 -> during reset oMEM_VALID=0 and both BUSY=1. After release: 1 IDLE cycle, then a read grant, first oMEM_VALID 2 cycles after release.
2. Write-only stream, 20 writes, iMEM_BUSY=0 -> bursts of 8/8/4 separated by 1 IDLE cycle. oMEM_DATA=0x00RRGGBB, oMEM_RW=1, order preserved.
3. Both requesters always valid, reads returned promptly, P_RD_OUTSTANDING raised to 15 so the burst limit (not the outstanding limit) governs -> alternating 8 reads / 8 writes.
4. Outstanding limit with default P_RD_OUTSTANDING=4, no iMEM_RD_VALID, read-only stream -> exactly 4 reads accepted, oRD_BUSY held. One return pulse -> exactly 1 more read accepted. Return pulse plus accept in the same cycle -> counter unchanged.
5. Urgent preemption: in a write burst after 3 writes, assert iRD_URGENT with iRD_VALID -> at most one more write, IDLE, then a read grant. A read burst continues past 8 while urgent and no write is pending.
6. iMEM_BUSY held 5 cycles with a request latched -> oMEM_* stable, both BUSY=1. On release the request issues once; data return 4 cycles later appears on oRD_DATA one cycle after iMEM_RD_VALID.
